// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A) and load (B) writeback paths.
// Optional stall counters are enabled by defining WB_ARB_STATS_EN.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_regWrite,
  output logic [ADDR_W-1:0] rf_writeRegister,
  output logic [DATA_W-1:0] rf_writeData,
  output logic              last_grant
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt_a,
  output logic [15:0]       stall_cnt_b
`endif
);

  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_grant_q, last_grant_d;
  logic              a_hs, b_hs;

  // A wins when B is idle or when B won the previous handshake.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!reset) begin
      if (a_valid && (!b_valid || last_grant_q)) a_ready = 1'b1;
      else if (b_valid)                          b_ready = 1'b1;
    end
  end

  assign a_hs = a_valid & a_ready;
  assign b_hs = b_valid & b_ready;

  always_comb begin
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    if (a_hs) begin
      we_d         = (a_addr != '0);
      waddr_d      = a_addr;
      wdata_d      = a_data;
      last_grant_d = 1'b0;
    end else if (b_hs) begin
      we_d         = (b_addr != '0);
      waddr_d      = b_addr;
      wdata_d      = b_data;
      last_grant_d = 1'b1;
    end
  end

  // Reset squashes any write already sitting in the output stage.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rf_regWrite      = we_q;
  assign rf_writeRegister = waddr_q;
  assign rf_writeData     = wdata_q;
  assign last_grant       = last_grant_q;

`ifdef WB_ARB_STATS_EN
  logic [15:0] stall_a_q, stall_a_d;
  logic [15:0] stall_b_q, stall_b_d;

  // Saturating counts of cycles spent waiting with a pending request.
  always_comb begin
    stall_a_d = stall_a_q;
    stall_b_d = stall_b_q;
    if (a_valid && !a_ready && (stall_a_q != 16'hFFFF)) stall_a_d = stall_a_q + 16'd1;
    if (b_valid && !b_ready && (stall_b_q != 16'hFFFF)) stall_b_d = stall_b_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_a_q <= '0;
      stall_b_q <= '0;
    end else begin
      stall_a_q <= stall_a_d;
      stall_b_q <= stall_b_d;
    end
  end

  assign stall_cnt_a = stall_a_q;
  assign stall_cnt_b = stall_b_q;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (regWrite / writeRegister / writeData) between two writeback requesters.
  - Requester A: ALU result path.
  - Requester B: memory-load path.
- Arbitration is round-robin with a valid/ready handshake per requester.
- Drives the register file write port from registered outputs, with one-cycle latency from handshake to write.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register index.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A has a write pending.
- a_addr  input  ADDR_W  requester A destination register.
- a_data  input  DATA_W  requester A write data.
- a_ready  output  1  A's request accepted this cycle.
- b_valid  input  1  requester B has a write pending.
- b_addr  input  ADDR_W  requester B destination register.
- b_data  input  DATA_W  requester B write data.
- b_ready  output  1  B's request accepted this cycle.
- rf_regWrite  output  1  write enable to register file.
- rf_writeRegister  output  ADDR_W  register file write index.
- rf_writeData  output  DATA_W  register file write data.
- last_grant  output  1  0 = A won the most recent handshake, 1 = B.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset state:
  - rf_regWrite=0, rf_writeRegister=0, rf_writeData=0.
  - last_grant=1, so A wins the first tie.
  - a_ready=0 and b_ready=0 in any cycle where reset=1.
- Grant logic (combinational from current valids and last_grant):
  - Only a_valid: a_ready=1.
  - Only b_valid: b_ready=1.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: both readys 0.
  - At most one ready is high per cycle.
- Handshake = valid & ready. Requesters hold valid, addr and data stable until their ready is seen. Valid must not drop without a handshake.
- On a handshake at edge N:
  - At edge N+1 registers load rf_writeRegister=addr and rf_writeData=data.
  - rf_regWrite=1 unless addr==0.
  - last_grant updates to the winner.
- Address 0: the request is accepted normally (ready pulses, last_grant updates) but rf_regWrite stays 0. Register 0 is never written.
- No handshake in a cycle: rf_regWrite=0 next cycle. rf_writeRegister and rf_writeData hold their last values.
- Throughput: one write per cycle sustained. Under continuous contention, grants alternate A,B,A,B. Neither requester waits more than 1 cycle once the other has been served.
- Same address from both requesters in one cycle: serialized in grant order. The later write wins in the register file.
- Reset mid-operation: a handshake in the reset cycle is impossible (readys forced 0). A write registered before reset is squashed: rf_regWrite=0 on the edge where reset is sampled.
- No FSM beyond the 1-bit last_grant pointer and the output register stage.

Optional Feature:
- Macro: WB_ARB_STATS_EN.
- When defined, adds two outputs:
  - stall_cnt_a  output  16
  - stall_cnt_b  output  16
- Each counter increments every cycle its requester has valid=1 and ready=0.
- Counters saturate at 16'hFFFF, clear on reset, and are not otherwise cleared.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, rf_regWrite=0, last_grant=1. First cycle after reset: a_ready=1.
- Single requester: a_valid=1, a_addr=5, a_data=32'hDEADBEEF for one handshake -> next cycle rf_regWrite=1, rf_writeRegister=5, rf_writeData=32'hDEADBEEF. The cycle after: rf_regWrite=0.
- Contention: both valid for 4 cycles, A writes r1..r4 = 1..4, B writes r8..r11 = 8..11 -> write order r1, r8, r2, r9. Each ready high on alternate cycles.
- Zero register: b_valid=1, b_addr=0, b_data=7 -> b_ready=1, last_grant=1, rf_regWrite stays 0 next cycle.
- Same address: A(r3=10) and B(r3=20) asserted together after reset -> r3 written 10 then 20. Final rf_writeData=20.
- Reset mid-stream: handshake A(r6=99) at edge N, reset=1 sampled at edge N+1 -> rf_regWrite=0 after N+1, no write to r6. With WB_ARB_STATS_EN, stall_cnt_a/b read 0 after reset.
